// File: rtl/alu3_operand_entry.sv
// Operand-entry sequencer: debounces key_n and steps through x, y, opcode capture for the 3-bit ALU.
// Optional idle abort in S_Y/S_OP is compiled in with `define ENTRY_TIMEOUT_EN.

module alu3_operand_entry #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned TIMEOUT_CYCLES  = 64
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       key_n,
    input  logic [2:0] sw,
    input  logic       op_sw,
    output logic [2:0] x,
    output logic [2:0] y,
    output logic       op,
    output logic       load,
    output logic       valid,
    output logic [1:0] phase,
    output logic       timeout
);

    localparam int unsigned DEB_W = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {
        S_X    = 2'b00,
        S_Y    = 2'b01,
        S_OP   = 2'b10,
        S_DONE = 2'b11
    } state_t;

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             key_deb_q, key_deb_d;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic             press_q, press_d;
    state_t           state_q, state_d;
    logic [2:0]       x_q, x_d;
    logic [2:0]       y_q, y_d;
    logic             op_q, op_d;
    logic             load_q, load_d;
    logic             valid_q, valid_d;

`ifdef ENTRY_TIMEOUT_EN
    localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              timeout_q, timeout_d;
`endif

    always_comb begin
        sync1_d   = key_n;
        sync2_d   = sync1_q;

        // Level flips on the edge that completes DEBOUNCE_CYCLES consecutive differing samples.
        key_deb_d = key_deb_q;
        deb_cnt_d = '0;
        if (sync2_q != key_deb_q) begin
            if (deb_cnt_q == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
                key_deb_d = sync2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
        press_d   = key_deb_q & ~key_deb_d;

        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        op_d      = op_q;
        load_d    = 1'b0;
`ifdef ENTRY_TIMEOUT_EN
        idle_d    = '0;
        timeout_d = 1'b0;
`endif
        if (press_q) begin
            unique case (state_q)
                S_X: begin
                    x_d     = sw;
                    state_d = S_Y;
                end
                S_Y: begin
                    y_d     = sw;
                    state_d = S_OP;
                end
                S_OP: begin
                    op_d    = op_sw;
                    load_d  = 1'b1;
                    state_d = S_DONE;
                end
                S_DONE: state_d = S_X;
            endcase
        end
`ifdef ENTRY_TIMEOUT_EN
        else if (state_q == S_Y || state_q == S_OP) begin
            if (idle_q == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
                state_d   = S_X;
                timeout_d = 1'b1;
            end else begin
                idle_d = idle_q + 1'b1;
            end
        end
`endif
        valid_d   = (state_d == S_DONE);
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            key_deb_q <= 1'b1;
            deb_cnt_q <= '0;
            press_q   <= 1'b0;
            state_q   <= S_X;
            x_q       <= '0;
            y_q       <= '0;
            op_q      <= 1'b0;
            load_q    <= 1'b0;
            valid_q   <= 1'b0;
`ifdef ENTRY_TIMEOUT_EN
            idle_q    <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            key_deb_q <= key_deb_d;
            deb_cnt_q <= deb_cnt_d;
            press_q   <= press_d;
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            op_q      <= op_d;
            load_q    <= load_d;
            valid_q   <= valid_d;
`ifdef ENTRY_TIMEOUT_EN
            idle_q    <= idle_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign x     = x_q;
    assign y     = y_q;
    assign op    = op_q;
    assign load  = load_q;
    assign valid = valid_q;
    assign phase = state_q;

`ifdef ENTRY_TIMEOUT_EN
    assign timeout = timeout_q;
`else
    // Without the idle counter the parameter only needs to stay referenced.
    assign timeout = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

endmodule

// File: tb/tb_alu3_operand_entry.sv
// Bench for alu3_operand_entry: directed entry/bounce/reset scenarios plus random key/switch
// activity, all checked every cycle against a window-based behavioural model.

module tb_alu3_operand_entry;

    localparam int unsigned DEB = 16;
    localparam int unsigned TMO = 64;

    logic       Clock  = 1'b0;
    logic       Resetn = 1'b0;
    logic       key_n  = 1'b1;
    logic [2:0] sw     = '0;
    logic       op_sw  = 1'b0;
    logic [2:0] x, y;
    logic       op, load, valid, timeout;
    logic [1:0] phase;

    alu3_operand_entry #(
        .DEBOUNCE_CYCLES(DEB),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .key_n  (key_n),
        .sw     (sw),
        .op_sw  (op_sw),
        .x      (x),
        .y      (y),
        .op     (op),
        .load   (load),
        .valid  (valid),
        .phase  (phase),
        .timeout(timeout)
    );

    always #5 Clock = ~Clock;

    int compared   = 0;
    int mismatched = 0;

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: raw key samples, the window of synchronized samples seen by the debouncer,
    // and the entry state as plain integers.
    int m_x = 0, m_y = 0, m_op = 0, m_load = 0, m_phase = 0, m_to = 0, m_idle = 0;
    bit m_level = 1'b1, m_press = 1'b0, m_s, m_nl, m_all;
    bit raw[$] = '{1'b1, 1'b1};
    bit win[$];

    always @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            m_x = 0; m_y = 0; m_op = 0; m_load = 0; m_phase = 0; m_to = 0; m_idle = 0;
            m_level = 1'b1; m_press = 1'b0;
            raw = '{1'b1, 1'b1};
            win.delete();
        end else begin
            m_load = 0;
            m_to   = 0;
            if (m_press) begin
                case (m_phase)
                    0: m_x = int'(sw);
                    1: m_y = int'(sw);
                    2: begin m_op = int'(op_sw); m_load = 1; end
                    default: ;
                endcase
                m_phase = (m_phase + 1) % 4;
                m_idle  = 0;
            end
`ifdef ENTRY_TIMEOUT_EN
            else if (m_phase == 1 || m_phase == 2) begin
                m_idle++;
                if (m_idle == TMO) begin
                    m_phase = 0;
                    m_to    = 1;
                    m_idle  = 0;
                end
            end
`endif
            // The debouncer at this edge sees the raw level sampled two edges earlier.
            m_s = raw[0];
            raw.push_back(key_n);
            void'(raw.pop_front());
            win.push_back(m_s);
            if (win.size() > DEB) void'(win.pop_front());
            m_all = (win.size() == DEB);
            for (int i = 0; i < win.size(); i++)
                if (win[i] == m_level) m_all = 1'b0;
            m_nl    = m_all ? ~m_level : m_level;
            m_press = m_level && !m_nl;
            m_level = m_nl;
        end
    end

    always @(negedge Clock) begin
        chk("x",       int'(x),       m_x);
        chk("y",       int'(y),       m_y);
        chk("op",      int'(op),      m_op);
        chk("load",    int'(load),    m_load);
        chk("valid",   int'(valid),   (m_phase == 3) ? 1 : 0);
        chk("phase",   int'(phase),   m_phase);
        chk("timeout", int'(timeout), m_to);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge Clock);
            #2;
        end
    endtask

    task automatic press(input logic [2:0] s, input logic o);
        sw    = s;
        op_sw = o;
        key_n = 1'b0;
        tick(DEB + 8);
        key_n = 1'b1;
        tick(DEB + 8);
    endtask

    initial begin
        int lt, nl, ce, ph0, ph1, nt, nld, len;

        Resetn = 1'b0;
        tick(3);
        Resetn = 1'b1;
        chk("rst_phase", int'(phase), 0);
        chk("rst_x",     int'(x),     0);
        chk("rst_y",     int'(y),     0);
        chk("rst_op",    int'(op),    0);
        chk("rst_load",  int'(load),  0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_timeout", int'(timeout), 0);
        tick(5);

        // Full entry: x=5, y=3, op=1, with load timing measured from the third fall.
        press(3'd5, 1'b0);
        press(3'd3, 1'b0);
        sw = 3'd0; op_sw = 1'b1; key_n = 1'b0;
        lt = -1; nl = 0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge Clock);
            @(negedge Clock);
            if (load) begin
                nl++;
                if (lt < 0) lt = k;
            end
        end
        chk("load_edge",  lt, 19);
        chk("load_width", nl, 1);
        @(posedge Clock); #2;
        key_n = 1'b1;
        tick(DEB + 8);
        chk("entry_x",     int'(x),     5);
        chk("entry_y",     int'(y),     3);
        chk("entry_op",    int'(op),    1);
        chk("entry_valid", int'(valid), 1);
        chk("entry_phase", int'(phase), 3);

        // Wrap-around keeps the completed operands.
        press(3'd7, 1'b0);
        chk("wrap_phase", int'(phase), 0);
        chk("wrap_valid", int'(valid), 0);
        chk("wrap_x",     int'(x),     5);
        chk("wrap_y",     int'(y),     3);
        chk("wrap_op",    int'(op),    1);

        // Held key with switches changing every cycle: only the value at edge 19 is taken.
        sw = 3'd0; key_n = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            tick(1);
            sw = 3'(k);
            if (k == 20) chk("held_phase", int'(phase), 1);
        end
        chk("held_x", int'(x), 2);
        chk("held_y", int'(y), 3);
        key_n = 1'b1;
        tick(DEB + 8);

        // Bounce: 5-cycle toggles, then held low from the last fall.
        sw = 3'd6;
        ph0 = int'(phase);
        for (int t = 0; t < 8; t++) begin
            key_n = (t % 2 == 0) ? 1'b0 : 1'b1;
            tick(5);
        end
        key_n = 1'b0;
        ce = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge Clock);
            @(negedge Clock);
            if (ce < 0 && int'(phase) != ph0) ce = k;
        end
        chk("bounce_event_edge", ce, 19);
        chk("bounce_phase", int'(phase), (ph0 + 1) % 4);
        @(posedge Clock); #2;
        ph1 = int'(phase);
        for (int t = 0; t < 8; t++) begin
            key_n = (t % 2 == 0) ? 1'b1 : 1'b0;
            tick(5);
        end
        key_n = 1'b1;
        tick(40);
        chk("release_quiet", int'(phase), ph1);
`ifndef ENTRY_TIMEOUT_EN
        chk("bounce_y", int'(y), 6);
`endif

        // Asynchronous reset mid-sequence, then a fresh full debounce is needed.
        #1;
        Resetn = 1'b0;
        #1;
        chk("arst_phase", int'(phase), 0);
        chk("arst_x",     int'(x),     0);
        chk("arst_y",     int'(y),     0);
        chk("arst_op",    int'(op),    0);
        chk("arst_load",  int'(load),  0);
        chk("arst_valid", int'(valid), 0);
        key_n = 1'b0;
        sw = 3'd7;
        tick(3);
        Resetn = 1'b1;
        ce = -1;
        for (int k = 1; k <= 25; k++) begin
            @(posedge Clock);
            @(negedge Clock);
            if (ce < 0 && phase != 2'd0) ce = k;
        end
        chk("post_rst_edge", ce, 19);
        chk("post_rst_x", int'(x), 7);
        @(posedge Clock); #2;
        key_n = 1'b1;
        tick(DEB + 8);

`ifdef ENTRY_TIMEOUT_EN
        nt = 0; nld = 0;
        for (int k = 0; k < 90; k++) begin
            @(negedge Clock);
            if (timeout) nt++;
            if (load) nld++;
        end
        chk("to_pulses", nt, 1);
        chk("to_load",   nld, 0);
        chk("to_phase",  int'(phase), 0);
        chk("to_x",      int'(x), 7);
        @(posedge Clock); #2;
`endif

        // Random key levels and durations, switches changing every cycle, rare resets.
        for (int seg = 0; seg < 150; seg++) begin
            key_n = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 45);
            repeat (len) begin
                sw    = 3'($urandom);
                op_sw = 1'($urandom);
                tick(1);
            end
            if ($urandom_range(0, 29) == 0) begin
                #1;
                Resetn = 1'b0;
                #3;
                Resetn = 1'b1;
            end
        end

        key_n = 1'b1;
        tick(60);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
